psram_burst_ctrl: RTL and testbench

Parametrised word-burst front-end for the quad-SPI PSRAM byte engine (`psram_controller`), replacing the single-word slow memory controller. Accepts word-addressed read/write requests of 1..`MAX_BURST` consecutive words from the SoC bus, serialises each word MSB-first into the byte engine, and reassembles read bytes into words. Generates the engine's slow-clock enable pulse and provides an optional stall watchdog with a sticky interrupt.

---
 rtl/psram_pkg.sv | 19 +
 rtl/psram_clk_div.sv | 38 +++
 rtl/psram_burst_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_psram_burst_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/psram_pkg.sv
// Shared constants for the PSRAM burst front-end: FSM encoding, engine
// address width and a clamped clog2 helper for parameter-derived widths.
package psram_pkg;

  localparam int M_ADDR_W = 24;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR_WAIT = 3'd1;
  localparam logic [2:0] S_WR_BYTE = 3'd2;
  localparam logic [2:0] S_RD_WAIT = 3'd3;
  localparam logic [2:0] S_RD_BYTE = 3'd4;
  localparam logic [2:0] S_END     = 3'd5;

  // Never returns 0 so that vectors derived from it stay legal.
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/psram_clk_div.sv
// Slow-clock enable generator and registered rising-edge detectors for the
// byte engine's handshake strobes.
module psram_clk_div #(
  parameter int CLKDIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic hold,
  input  logic byte_available,
  input  logic ready_for_next_byte,
  output logic clk_pulse_slow,
  output logic rd_ev,
  output logic wr_ev
);

  localparam int DW = $clog2(CLKDIV);

  logic [DW-1:0] div;
  logic [1:0]    ba_q, rn_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div  <= '0;
      ba_q <= '0;
      rn_q <= '0;
    end else begin
      div  <= div + DW'(1);
      ba_q <= {ba_q[0], byte_available};
      rn_q <= {rn_q[0], ready_for_next_byte};
    end
  end

  // Withholding the enable freezes the engine while a write word is missing.
  assign clk_pulse_slow = (div == '0) && !hold;
  assign rd_ev = ba_q[0] & ~ba_q[1];
  assign wr_ev = rn_q[0] & ~rn_q[1];

endmodule

// File: rtl/psram_burst_ctrl.sv
// Word-burst front-end for the quad-SPI PSRAM byte engine.
// Define PSRAM_BURST_TIMEOUT_EN to enable the stall watchdog and sticky irq.
module psram_burst_ctrl
  import psram_pkg::*;
#(
  parameter int WORD_BYTES  = 4,
  parameter int ADDR_W      = 22,
  parameter int MAX_BURST   = 8,
  parameter int CLKDIV      = 4,
  parameter int TIMEOUT_CYC = 4096,
  localparam int DW = 8 * WORD_BYTES,
  localparam int LW = clog2_min1(MAX_BURST)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   a,
  input  logic [LW-1:0]       len,
  input  logic                rd,
  input  logic                we,
  input  logic [DW-1:0]       wdata,
  input  logic                wvalid,
  output logic                wready,
  output logic [DW-1:0]       rdata,
  output logic                rvalid,
  output logic                ready,
  output logic                irq,
  input  logic                irq_clr,
  output logic                clk_pulse_slow,
  output logic                m_rd,
  output logic                m_rend,
  output logic                m_we,
  output logic                m_wend,
  output logic [M_ADDR_W-1:0] m_a,
  output logic [7:0]          m_din,
  input  logic [7:0]          m_dout,
  input  logic                m_byte_available,
  input  logic                m_ready_for_next_byte,
  input  logic                m_ready
);

  localparam int AB = $clog2(WORD_BYTES);
  localparam int CW = $clog2(WORD_BYTES * MAX_BURST + 1);
  localparam int BW = clog2_min1(WORD_BYTES);
  localparam logic [BW-1:0] LAST_B = BW'(WORD_BYTES - 1);

  logic [2:0]    state;
  logic          is_wr, rst_done, rd_ev, wr_ev, tmo;
  logic [CW-1:0] cnt;
  logic [BW-1:0] bcnt;
  logic [DW-1:0] shreg, rd_nxt;

  psram_clk_div #(.CLKDIV(CLKDIV)) u_div (
    .clk                 (clk),
    .rst_n               (rst_n),
    .hold                (wready),
    .byte_available      (m_byte_available),
    .ready_for_next_byte (m_ready_for_next_byte),
    .clk_pulse_slow      (clk_pulse_slow),
    .rd_ev               (rd_ev),
    .wr_ev               (wr_ev)
  );

  assign ready  = rst_done && (state == S_IDLE) && m_ready && !(rd || we);
  assign m_din  = shreg[DW-1 -: 8];
  assign rd_nxt = (shreg << 8) | DW'(m_dout);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      is_wr    <= 1'b0;
      rst_done <= 1'b0;
      cnt      <= '0;
      bcnt     <= '0;
      shreg    <= '0;
      m_a      <= '0;
      m_we     <= 1'b0;
      m_rd     <= 1'b0;
      m_wend   <= 1'b0;
      m_rend   <= 1'b0;
      wready   <= 1'b0;
      rvalid   <= 1'b0;
      rdata    <= '0;
    end else begin
      rst_done <= 1'b1;
      m_we     <= 1'b0;
      m_rd     <= 1'b0;
      m_wend   <= 1'b0;
      m_rend   <= 1'b0;
      rvalid   <= 1'b0;
      if (tmo) begin
        state  <= S_IDLE;
        wready <= 1'b0;
        m_wend <= is_wr;
        m_rend <= !is_wr;
      end else begin
        case (state)
          S_IDLE: if (we || rd) begin
            is_wr <= we;
            m_a   <= M_ADDR_W'(a) << AB;
            cnt   <= CW'(WORD_BYTES) * (CW'(len) + CW'(1));
            bcnt  <= '0;
            shreg <= wdata;
            state <= we ? S_WR_WAIT : S_RD_WAIT;
          end
          S_WR_WAIT: if (m_ready) begin
            m_we  <= 1'b1;
            state <= S_WR_BYTE;
          end
          S_RD_WAIT: if (m_ready) begin
            m_rd  <= 1'b1;
            state <= S_RD_BYTE;
          end
          S_WR_BYTE: begin
            if (wready) begin
              if (wvalid) begin
                shreg  <= wdata;
                wready <= 1'b0;
              end
            end else if (wr_ev) begin
              shreg <= shreg << 8;
              cnt   <= cnt - CW'(1);
              if (bcnt == LAST_B) begin
                bcnt   <= '0;
                wready <= (cnt != CW'(1));
              end else begin
                bcnt <= bcnt + BW'(1);
              end
              if (cnt == CW'(1)) begin
                state  <= S_END;
                m_wend <= 1'b1;
              end
            end
          end
          S_RD_BYTE: if (rd_ev) begin
            shreg <= rd_nxt;
            cnt   <= cnt - CW'(1);
            if (bcnt == LAST_B) begin
              bcnt   <= '0;
              rvalid <= 1'b1;
              rdata  <= rd_nxt;
            end else begin
              bcnt <= bcnt + BW'(1);
            end
            if (cnt == CW'(1)) begin
              state  <= S_END;
              m_rend <= 1'b1;
            end
          end
          S_END:   state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef PSRAM_BURST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] wd;
  logic [2:0]    state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd      <= '0;
      state_q <= S_IDLE;
      irq     <= 1'b0;
    end else begin
      state_q <= state;
      if (state != state_q || rd_ev || wr_ev || state == S_IDLE) wd <= '0;
      else                                                        wd <= wd + TW'(1);
      // A timeout in the same cycle as a clear wins.
      if (tmo)          irq <= 1'b1;
      else if (irq_clr) irq <= 1'b0;
    end
  end

  assign tmo = (state != S_IDLE) && (wd == TW'(TIMEOUT_CYC));
`else
  logic unused_cfg;
  assign unused_cfg = irq_clr ^ TIMEOUT_CYC[0];
  assign tmo = 1'b0;
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_psram_burst_ctrl.sv
// Directed bench for psram_burst_ctrl with a behavioural byte-engine model.
module tb_psram_burst_ctrl;

  logic        clk, rst_n;
  logic [21:0] a;
  logic [2:0]  len;
  logic        rd, we, wvalid, irq_clr;
  logic [31:0] wdata;
  logic        wready, rvalid, ready, irq;
  logic [31:0] rdata;
  logic        clk_pulse_slow, m_rd, m_rend, m_we, m_wend;
  logic [23:0] m_a;
  logic [7:0]  m_din, m_dout;
  logic        m_byte_available, m_ready_for_next_byte, m_ready;

  psram_burst_ctrl dut (
    .clk(clk), .rst_n(rst_n), .a(a), .len(len), .rd(rd), .we(we),
    .wdata(wdata), .wvalid(wvalid), .wready(wready), .rdata(rdata),
    .rvalid(rvalid), .ready(ready), .irq(irq), .irq_clr(irq_clr),
    .clk_pulse_slow(clk_pulse_slow), .m_rd(m_rd), .m_rend(m_rend),
    .m_we(m_we), .m_wend(m_wend), .m_a(m_a), .m_din(m_din),
    .m_dout(m_dout), .m_byte_available(m_byte_available),
    .m_ready_for_next_byte(m_ready_for_next_byte), .m_ready(m_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk = 0, n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Engine model and monitors, all evaluated on the falling edge.
  logic [7:0]  wr_bytes[$];
  logic [7:0]  rd_src[$];
  logic [31:0] rd_words[$];
  logic [23:0] last_a;
  int mode = 0, ph = 0, stall_after = -1, nrd_sent = 0, cyc = 0;
  int n_we = 0, n_rd = 0, n_wend = 0, n_rend = 0, n_wrdy = 0;
  int last_ba_cyc = 0, rend_cyc = 0;
  logic prev_wready = 1'b0;

  initial begin
    m_ready = 1'b1; m_byte_available = 1'b0; m_ready_for_next_byte = 1'b0; m_dout = 8'h00;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        mode = 0; ph = 0; m_ready = 1'b1;
        m_byte_available = 1'b0; m_ready_for_next_byte = 1'b0; prev_wready = 1'b0;
      end else begin
        if (rvalid) rd_words.push_back(rdata);
        if (wready && !prev_wready) n_wrdy++;
        prev_wready = wready;
        if (m_wend) n_wend++;
        if (m_rend) begin n_rend++; rend_cyc = cyc; end
        if (m_wend || m_rend) begin
          mode = 0; m_ready = 1'b1; m_byte_available = 1'b0; m_ready_for_next_byte = 1'b0;
        end else if (m_we) begin
          mode = 1; ph = 0; m_ready = 1'b0; last_a = m_a; n_we++;
        end else if (m_rd) begin
          mode = 2; ph = 0; m_ready = 1'b0; last_a = m_a; n_rd++; nrd_sent = 0;
        end else if (mode != 0 && clk_pulse_slow) begin
          if (ph == 0) begin
            if (mode == 1) begin
              wr_bytes.push_back(m_din);
              m_ready_for_next_byte = 1'b1;
            end else if (nrd_sent != stall_after && rd_src.size() > 0) begin
              m_dout = rd_src.pop_front();
              m_byte_available = 1'b1;
              nrd_sent++;
              last_ba_cyc = cyc;
            end
            ph = 1;
          end else begin
            m_ready_for_next_byte = 1'b0; m_byte_available = 1'b0; ph = 0;
          end
        end
      end
    end
  end

  task automatic wait_ready(input string tag, input int bound);
    int t = 0;
    while (!ready && t < bound) begin @(negedge clk); t++; end
    check(tag, ready, 1'b1);
  endtask

  task automatic req(input logic w, input logic r, input logic [21:0] addr,
                     input logic [2:0] l, input logic [31:0] d);
    wait_ready("pre_req_ready", 3000);
    a = addr; len = l; we = w; rd = r; wdata = d;
    #1 check("ready_drop", ready, 1'b0);
    @(negedge clk);
    we = 1'b0; rd = 1'b0;
  endtask

  task automatic pop_word(output logic [31:0] w);
    w = 32'h0;
    for (int i = 0; i < 4; i++)
      w = {w[23:0], (wr_bytes.size() > 0) ? wr_bytes.pop_front() : 8'hEE};
  endtask

  logic [31:0] bw [4] = '{32'h01234567, 32'h89ABCDEF, 32'hDEADBEEF, 32'hCAFEF00D};
  int          dly [4] = '{0, 10, 0, 2};
  logic [31:0] w;
  int b_we, b_rd, b_rend, b_wrdy, t;

  initial begin
    rst_n = 1'b0; a = '0; len = '0; rd = 1'b0; we = 1'b0; wvalid = 1'b0;
    wdata = '0; irq_clr = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_ready", ready, 1'b0);
    check("rst_outs", {rvalid, wready, irq, m_rd, m_we, m_rend, m_wend}, 7'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_m_a", m_a, 24'h0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("ready_after_rst", ready, 1'b1);

    // single write
    req(1'b1, 1'b0, 22'h000010, 3'd0, 32'hA1B2C3D4);
    wait_ready("wr1_done", 3000);
    check("wr1_m_a", last_a, 24'h000040);
    pop_word(w);
    check("wr1_bytes", w, 32'hA1B2C3D4);
    check("wr1_extra", wr_bytes.size(), 0);
    check("wr1_wend", n_wend, 1);
    check("wr1_wready", n_wrdy, 0);

    // single read of the same word
    rd_src = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    req(1'b0, 1'b1, 22'h000010, 3'd0, 32'h0);
    wait_ready("rd1_done", 3000);
    check("rd1_m_a", last_a, 24'h000040);
    check("rd1_nrv", rd_words.size(), 1);
    if (rd_words.size() > 0) check("rd1_data", rd_words.pop_front(), 32'hA1B2C3D4);
    check("rd1_rend", n_rend, 1);
    check("rd1_rdata_hold", rdata, 32'hA1B2C3D4);

    // burst write with late wvalid on word 2
    b_wrdy = n_wrdy;
    req(1'b1, 1'b0, 22'h000100, 3'd3, bw[0]);
    for (int k = 1; k < 4; k++) begin
      t = 0;
      while (!wready && t < 2000) begin @(negedge clk); t++; end
      check("bwr_wready_up", wready, 1'b1);
      repeat (dly[k]) @(negedge clk);
      wdata = bw[k]; wvalid = 1'b1;
      @(negedge clk);
      wvalid = 1'b0;
      #1 check("bwr_wready_down", wready, 1'b0);
    end
    wait_ready("bwr_done", 3000);
    check("bwr_m_a", last_a, 24'h000400);
    check("bwr_nbytes", wr_bytes.size(), 16);
    for (int k = 0; k < 4; k++) begin
      pop_word(w);
      check("bwr_word", w, bw[k]);
    end
    check("bwr_hs", n_wrdy - b_wrdy, 3);
    check("bwr_wend", n_wend, 2);

    // burst read of 8 words with stray rd pulses
    for (int i = 0; i < 8; i++) begin
      w = 32'h10203040 + 32'h01010101 * i;
      for (int j = 3; j >= 0; j--) rd_src.push_back(w[j*8 +: 8]);
    end
    b_rd = n_rd;
    req(1'b0, 1'b1, 22'h000200, 3'd7, 32'h0);
    for (int p = 0; p < 3; p++) begin
      repeat (30) @(negedge clk);
      a = 22'h3FFFFF; rd = 1'b1;
      @(negedge clk);
      rd = 1'b0;
    end
    wait_ready("brd_done", 3000);
    check("brd_m_a", last_a, 24'h000800);
    check("brd_nrv", rd_words.size(), 8);
    for (int i = 0; i < 8; i++)
      if (rd_words.size() > 0) check("brd_word", rd_words.pop_front(), 32'h10203040 + 32'h01010101 * i);
    check("brd_nrd", n_rd - b_rd, 1);
    check("brd_rend", n_rend, 2);

    // rd and we together: the write wins
    b_we = n_we; b_rd = n_rd; b_rend = n_rend;
    req(1'b1, 1'b1, 22'h000003, 3'd0, 32'h5A6B7C8D);
    wait_ready("both_done", 3000);
    check("both_we", n_we - b_we, 1);
    check("both_rd", n_rd - b_rd, 0);
    check("both_rend", n_rend - b_rend, 0);
    check("both_m_a", last_a, 24'h00000C);
    pop_word(w);
    check("both_bytes", w, 32'h5A6B7C8D);

    // reset in the middle of a burst write
    req(1'b1, 1'b0, 22'h000020, 3'd3, 32'h11223344);
    t = 0;
    while (!wready && t < 2000) begin @(negedge clk); t++; end
    check("mid_wready", wready, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_outs", {rvalid, wready, irq, m_rd, m_we, m_rend, m_wend}, 7'h0);
    check("mid_rst_rdata", rdata, 32'h0);
    check("mid_rst_m_a", m_a, 24'h0);
    check("mid_rst_ready", ready, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_ready("mid_recover", 20);
    wr_bytes.delete();
    check("irq_idle", irq, 1'b0);

`ifdef PSRAM_BURST_TIMEOUT_EN
    // engine stalls after two bytes; watchdog ends the read
    rd_words.delete();
    rd_src = '{8'h01, 8'h02, 8'h03, 8'h04};
    stall_after = 2;
    b_rend = n_rend;
    req(1'b0, 1'b1, 22'h000040, 3'd0, 32'h0);
    wait_ready("tmo_done", 6000);
    check("tmo_rend", n_rend - b_rend, 1);
    check("tmo_lat_ok", (rend_cyc - last_ba_cyc >= 4096) && (rend_cyc - last_ba_cyc <= 4110), 1'b1);
    check("tmo_irq", irq, 1'b1);
    check("tmo_norv", rd_words.size(), 0);
    irq_clr = 1'b1;
    @(negedge clk);
    irq_clr = 1'b0;
    check("tmo_irq_clr", irq, 1'b0);
    stall_after = -1;
    rd_src.delete();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "global timeout");
  end

endmodule
